err_meas_sched: RTL and testbench
=================================

Name: err_meas_sched

Overview:
- Measurement-window scheduler for the error-statistics accumulators (DC error / squared error).
- Time-shares one accumulator between up to NUM_SRC error sources, in ascending source order.
- For each window it drives the accumulator's clear, enable and hold controls and the upstream source-select mux.
- Guarantees each latched result is the sum of exactly 2^WIN_LOG2 symbol samples, so software can divide by a power of two.

Parameters:
- WIN_LOG2, default `LFSR_LEN: log2 of the window length in symbols.
- NUM_SRC, default 4: number of error sources, fixed at 4 in this revision.
- CNT_W, default 16: width of the completed-window counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  symbol strobe, one clk cycle wide.
- start  in  1  pulse; begins a sweep when in IDLE.
- abort  in  1  pulse; terminates any sweep.
- continuous  in  1  when 1, the sweep repeats until aborted.
- src_mask  in  NUM_SRC  sources to measure; sampled at start.
- src_sel  out  2  error-mux select for the active source.
- acc_clear  out  1  synchronous clear to the accumulator.
- acc_en  out  1  gated symbol enable to the accumulator.
- acc_hold  out  1  result-latch qualifier to the accumulator.
- busy  out  1  high in any state other than IDLE.
- win_done  out  1  one-cycle pulse after each result is latched.
- done_src  out  2  source index of the latched result; valid with win_done.
- sweep_done  out  1  one-cycle pulse at the end of a non-continuous sweep.
- win_count  out  CNT_W  completed windows since start; saturates at all-ones.

Behaviour:
- Reset: every output is 0; state is IDLE; internal mask and counters are 0.
- States: IDLE, CLEAR, RUN, LATCH, NEXT.
- IDLE:
  - start=1 with src_mask!=0: register the mask, set src_sel to its lowest set bit, clear win_count, go to CLEAR.
  - start with src_mask==0: ignored.
- CLEAR:
  - acc_clear=1 for exactly one clk cycle, independent of clk_en.
  - Symbol counter (WIN_LOG2+1 bits) cleared; go to RUN.
- RUN:
  - acc_en = clk_en, combinational pass-through.
  - Counter increments on clk_en.
  - On the clk_en where counter == 2^WIN_LOG2-1, go to LATCH; 2^WIN_LOG2 samples have then been accumulated.
- LATCH:
  - acc_hold=1 from entry, i.e. before the next clk_en; acc_en = clk_en.
  - On clk_en, the accumulator latches the full window sum. The extra sample added on that edge is discarded by the next clear.
  - Go to NEXT.
- NEXT (one cycle):
  - Pulse win_done, with done_src = src_sel of the window just finished.
  - Increment win_count, saturating.
  - Select the next set mask bit above src_sel and go to CLEAR.
  - If none remains and continuous=1: wrap to the lowest set bit and go to CLEAR.
  - Otherwise: pulse sweep_done and go to IDLE.
- acc_hold is 0 in every state except LATCH. acc_en is 0 in IDLE, CLEAR and NEXT.
- Latency:
  - start to acc_clear: 1 cycle.
  - Last LATCH clk_en to win_done: 1 cycle.
- abort: from any state, go to IDLE on the next edge and deassert all outputs. No win_done or sweep_done is generated. abort has priority over start and over every other transition.
- start while busy: ignored.
- src_mask changes after start: ignored until the next start.
- continuous is sampled in NEXT, so clearing it mid-window ends the sweep after the current pass.
- reset_n low mid-window: immediate return to the reset values, with no partial hold.
- Single-source mask: windows run back-to-back on the same src_sel (continuous mode) or a single window is run (non-continuous).

Decomposition:
- Shared package / defines.vh:
  - State encodings (IDLE=0 … NEXT=4).
  - SRC_W=2.
  - WIN_LOG2 default taken from `LFSR_LEN.
- Sub-module win_sym_counter: symbol counter with clear, enable and terminal-count flag. Reused by the squared-error path.
- Next-source priority select: a local function, not a module.

Test Plan (WIN_LOG2=3, so 8-symbol windows; clk_en every 4th clk):
- mask=4'b0101, continuous=0, start:
  - acc_clear once with src_sel=0; 8 gated acc_en; acc_hold; win_done with done_src=0.
  - Same sequence for src_sel=2, then sweep_done; win_count=2; busy drops.
- Hold alignment: drive err=1 through an attached err_dc_gen (LFSR_LEN=3) -> acc_dc_err_out=1, i.e. 8/2^3, latched exactly on the LATCH clk_en.
- continuous=1, mask=4'b1000 -> src_sel stays 3; win_done every 9 clk_en; win_count 1,2,3…; no sweep_done.
- abort asserted in RUN after 5 symbols -> IDLE next cycle; acc_hold never asserted; no win_done; outputs 0.
- start with mask=0 -> busy stays 0. start while busy -> no restart; sequence unchanged.
- reset_n pulsed low in LATCH -> all outputs 0 asynchronously; a later start restarts cleanly from CLEAR with win_count=0.

Source files
------------

// File: rtl/err_meas_sched_pkg.sv
// Shared types and constants for the error-statistics window scheduler.
// Also holds the source priority picker used by the top-level FSM.
`ifndef LFSR_LEN
`define LFSR_LEN 3
`endif

package err_meas_sched_pkg;

    localparam int unsigned WIN_LOG2_DEF = `LFSR_LEN;

    localparam int unsigned SRC_W       = 2;
    localparam int unsigned NUM_SRC_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_LATCH = 3'd3,
        ST_NEXT  = 3'd4
    } meas_state_e;

    typedef struct packed {
        logic             found;
        logic [SRC_W-1:0] idx;
    } src_pick_t;

    // Lowest set mask bit, optionally restricted to bits strictly above cur.
    function automatic src_pick_t pick_src(input logic [NUM_SRC_DEF-1:0] mask,
                                           input logic [SRC_W-1:0]       cur,
                                           input logic                   above);
        src_pick_t pick;
        pick = '0;
        for (int i = int'(NUM_SRC_DEF) - 1; i >= 0; i--) begin
            if (mask[i] && (!above || (i > int'(cur)))) begin
                pick.found = 1'b1;
                pick.idx   = SRC_W'(i);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/err_meas_sched_win_sym_counter.sv
// Symbol counter for one measurement window; flags the last symbol of a
// 2^WIN_LOG2-symbol window.
module err_meas_sched_win_sym_counter #(
    parameter int unsigned WIN_LOG2 = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic tc_c
);

    localparam int unsigned      SYM_W  = WIN_LOG2 + 1;
    localparam logic [SYM_W-1:0] TC_VAL = SYM_W'((1 << WIN_LOG2) - 1);

    logic [SYM_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + SYM_W'(1);
        end
    end

    assign tc_c = (count == TC_VAL);

endmodule

// File: rtl/err_meas_sched.sv
// Measurement-window scheduler: time-shares one error accumulator across the
// masked sources, producing exact power-of-two window sums.
module err_meas_sched
    import err_meas_sched_pkg::*;
#(
    parameter int unsigned WIN_LOG2 = WIN_LOG2_DEF,
    parameter int unsigned NUM_SRC  = NUM_SRC_DEF,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clk_en,
    input  logic               start,
    input  logic               abort,
    input  logic               continuous,
    input  logic [NUM_SRC-1:0] src_mask,
    output logic [SRC_W-1:0]   src_sel,
    output logic               acc_clear,
    output logic               acc_en,
    output logic               acc_hold,
    output logic               busy,
    output logic               win_done,
    output logic [SRC_W-1:0]   done_src,
    output logic               sweep_done,
    output logic [CNT_W-1:0]   win_count
);

    meas_state_e        state, state_nxt;
    logic [NUM_SRC-1:0] mask_q, mask_nxt;
    logic [SRC_W-1:0]   src_nxt, done_src_nxt;
    logic [CNT_W-1:0]   win_cnt_nxt;
    logic               win_done_nxt, sweep_done_nxt;
    logic               acc_en_gate;
    logic               cnt_clr_c, cnt_en_c, tc_c;
    src_pick_t          pick_start, pick_above, pick_wrap;

    err_meas_sched_win_sym_counter #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_sym_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (cnt_clr_c),
        .en      (cnt_en_c),
        .tc_c    (tc_c)
    );

    // Next-state and next-output decode; abort overrides every transition.
    always_comb begin
        state_nxt      = state;
        mask_nxt       = mask_q;
        src_nxt        = src_sel;
        win_cnt_nxt    = win_count;
        done_src_nxt   = '0;
        win_done_nxt   = 1'b0;
        sweep_done_nxt = 1'b0;
        cnt_clr_c      = 1'b0;
        cnt_en_c       = 1'b0;
        pick_start     = pick_src(NUM_SRC_DEF'(src_mask), '0, 1'b0);
        pick_above     = pick_src(NUM_SRC_DEF'(mask_q), src_sel, 1'b1);
        pick_wrap      = pick_src(NUM_SRC_DEF'(mask_q), '0, 1'b0);

        if (abort) begin
            state_nxt   = ST_IDLE;
            mask_nxt    = '0;
            src_nxt     = '0;
            win_cnt_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && pick_start.found) begin
                        mask_nxt    = src_mask;
                        src_nxt     = pick_start.idx;
                        win_cnt_nxt = '0;
                        state_nxt   = ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    cnt_clr_c = 1'b1;
                    state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    cnt_en_c = clk_en;
                    if (clk_en && tc_c) begin
                        state_nxt = ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    // Count the window with the pulse so win_count and win_done agree.
                    if (clk_en) begin
                        state_nxt    = ST_NEXT;
                        win_done_nxt = 1'b1;
                        done_src_nxt = src_sel;
                        win_cnt_nxt  = (win_count == {CNT_W{1'b1}}) ? win_count
                                                                    : win_count + CNT_W'(1);
                    end
                end
                ST_NEXT: begin
                    if (pick_above.found) begin
                        src_nxt   = pick_above.idx;
                        state_nxt = ST_CLEAR;
                    end else if (continuous && pick_wrap.found) begin
                        src_nxt   = pick_wrap.idx;
                        state_nxt = ST_CLEAR;
                    end else begin
                        sweep_done_nxt = 1'b1;
                        state_nxt      = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs, decoded from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            mask_q      <= '0;
            src_sel     <= '0;
            win_count   <= '0;
            done_src    <= '0;
            win_done    <= 1'b0;
            sweep_done  <= 1'b0;
            acc_clear   <= 1'b0;
            acc_hold    <= 1'b0;
            acc_en_gate <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            mask_q      <= mask_nxt;
            src_sel     <= src_nxt;
            win_count   <= win_cnt_nxt;
            done_src    <= done_src_nxt;
            win_done    <= win_done_nxt;
            sweep_done  <= sweep_done_nxt;
            acc_clear   <= (state_nxt == ST_CLEAR);
            acc_hold    <= (state_nxt == ST_LATCH);
            acc_en_gate <= (state_nxt == ST_RUN) || (state_nxt == ST_LATCH);
            busy        <= (state_nxt != ST_IDLE);
        end
    end

    // Symbol strobe passes straight through while a window is accumulating.
    assign acc_en = clk_en & acc_en_gate;

endmodule

// File: tb/tb_err_meas_sched.sv
// Self-checking bench for err_meas_sched: 8-symbol windows, clk_en every 4th
// clk, 2-bit window counter so saturation is reachable.
module tb_err_meas_sched;

    localparam int unsigned WIN_LOG2 = 3;
    localparam int unsigned CNT_W    = 2;
    localparam int          WIN_LEN  = 8;
    localparam int          CNT_MAX  = 3;

    logic       clk, reset_n, clk_en, start, abort, continuous;
    logic [3:0] src_mask;
    logic [1:0] src_sel, done_src;
    logic       acc_clear, acc_en, acc_hold, busy, win_done, sweep_done;
    logic [CNT_W-1:0] win_count;

    err_meas_sched #(
        .WIN_LOG2 (WIN_LOG2),
        .NUM_SRC  (4),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clk_en     (clk_en),
        .start      (start),
        .abort      (abort),
        .continuous (continuous),
        .src_mask   (src_mask),
        .src_sel    (src_sel),
        .acc_clear  (acc_clear),
        .acc_en     (acc_en),
        .acc_hold   (acc_hold),
        .busy       (busy),
        .win_done   (win_done),
        .done_src   (done_src),
        .sweep_done (sweep_done),
        .win_count  (win_count)
    );

    typedef struct {
        logic [1:0] src;
        int         cnt;
    } exp_t;

    typedef struct {
        logic [3:0] mask;
        logic       cont;
        int         n_win;
        int         exp_count;
        int         exp_sweeps;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[5];

    int checks, failures;
    int cyc;
    int run_en, hold_en, n_sweep, n_windone;
    int acc_sum, latched;
    logic [1:0] clr_src;
    logic hold_seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle symbol strobe every 4th clk.
    initial begin
        clk_en = 1'b0;
        cyc    = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            clk_en = ((cyc % 4) == 0);
        end
    end

    // Attached accumulator with err=1 on every gated symbol.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_sum <= 0;
            latched <= 0;
        end else if (acc_clear) begin
            acc_sum <= 0;
        end else if (acc_en) begin
            if (acc_hold) latched <= acc_sum;
            acc_sum <= acc_sum + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({busy, acc_clear, acc_hold, acc_en, win_done, sweep_done,
                    src_sel, done_src, win_count});
    endfunction

    function automatic logic [1:0] lowest(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        if (m[0])      r = 2'd0;
        else if (m[1]) r = 2'd1;
        else if (m[2]) r = 2'd2;
        else if (m[3]) r = 2'd3;
        return r;
    endfunction

    task automatic push_expected(input logic [3:0] m, input int n);
        exp_t e;
        int   cur;
        int   nx;
        cur = -1;
        for (int k = 0; k < n; k++) begin
            nx = -1;
            for (int b = 0; b < 4; b++) if (m[b] && b > cur && nx < 0) nx = b;
            if (nx < 0) nx = int'(lowest(m));
            e.src = 2'(nx);
            e.cnt = (k + 1 > CNT_MAX) ? CNT_MAX : k + 1;
            sb.push_back(e);
            cur = nx;
        end
    endtask

    // Scoreboard: each window result is compared as it is latched.
    always @(negedge clk) begin
        if (reset_n) begin
            if (acc_clear) begin
                run_en  = 0;
                hold_en = 0;
                clr_src = src_sel;
            end
            if (acc_en && !acc_hold) run_en++;
            if (acc_en && acc_hold) hold_en++;
            if (acc_hold) hold_seen = 1'b1;
            if (sweep_done) n_sweep++;
            if (win_done) begin
                n_windone++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_win_done actual_src=%0d required=no_window", done_src);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_src", 32'(done_src), 32'(mon_e.src));
                    check("win_count_at_done", 32'(win_count), 32'(mon_e.cnt));
                    check("clear_src", 32'(clr_src), 32'(mon_e.src));
                    check("run_samples", 32'(run_en), 32'(WIN_LEN));
                    check("hold_samples", 32'(hold_en), 32'(1));
                    check("latched_sum", 32'(latched), 32'(WIN_LEN));
                end
            end
        end
    end

    task automatic do_start(input logic [3:0] m, input logic c, input int n, input bit push, input bit chk);
        if (push) push_expected(m, n);
        @(posedge clk); #1;
        src_mask   = m;
        continuous = c;
        start      = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        src_mask = ~m;
        if (chk) begin
            @(negedge clk);
            check("clear_after_start", 32'({acc_clear, busy, src_sel, win_count}),
                  32'({1'b1, 1'b1, lowest(m), CNT_W'(0)}));
        end
    endtask

    task automatic do_abort();
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("outputs_after_abort", outs(), 32'(0));
    endtask

    task automatic wait_q_empty(input int max_cyc);
        for (int k = 0; k < max_cyc && sb.size() != 0; k++) begin
            @(negedge clk); #1;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'(0));
        sb.delete();
    endtask

    task automatic wait_sweep(input int base, input int max_cyc);
        for (int k = 0; k < max_cyc && n_sweep == base; k++) begin
            @(negedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   sweeps0;
        int   win0;

        checks = 0; failures = 0;
        run_en = 0; hold_en = 0; n_sweep = 0; n_windone = 0;
        clr_src = 2'd0; hold_seen = 1'b0;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; continuous = 1'b0; src_mask = 4'd0;

        //        mask     cont  n_win  final_count  sweeps
        vecs[0] = '{4'b0101, 1'b0, 2,     2,           1};
        vecs[1] = '{4'b0000, 1'b0, 0,     2,           0};
        vecs[2] = '{4'b1000, 1'b1, 3,     0,           0};
        vecs[3] = '{4'b1111, 1'b0, 4,     CNT_MAX,     1};
        vecs[4] = '{4'b0110, 1'b1, 5,     0,           0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", outs(), 32'(0));
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", outs(), 32'(0));

        for (int i = 0; i < 5; i++) begin
            v       = vecs[i];
            sweeps0 = n_sweep;
            if (v.mask == 4'd0) begin
                do_start(v.mask, v.cont, 0, 1'b0, 1'b0);
                repeat (3) @(negedge clk);
                #1;
            end else begin
                do_start(v.mask, v.cont, v.n_win, 1'b1, 1'b1);
                wait_q_empty(v.n_win * 60 + 40);
                if (v.cont) do_abort();
                else        wait_sweep(sweeps0, 40);
            end
            check("final_win_count", 32'(win_count), 32'(v.exp_count));
            check("sweep_done_pulses", 32'(n_sweep - sweeps0), 32'(v.exp_sweeps));
            check("busy_after_vector", 32'(busy), 32'(0));
        end

        // Abort in RUN after 5 symbols: no hold, no result.
        hold_seen = 1'b0;
        do_start(4'b0001, 1'b0, 1, 1'b1, 1'b1);
        for (int k = 0; k < 60 && run_en < 5; k++) begin
            @(negedge clk); #1;
        end
        check("abort_run_samples", 32'(run_en), 32'(5));
        do_abort();
        sb.delete();
        win0    = n_windone;
        sweeps0 = n_sweep;
        repeat (60) @(negedge clk);
        #1;
        check("abort_no_win_done", 32'(n_windone - win0), 32'(0));
        check("abort_no_sweep_done", 32'(n_sweep - sweeps0), 32'(0));
        check("abort_no_hold", 32'(hold_seen), 32'(0));

        // Start while busy with another mask: sweep must proceed unchanged.
        sweeps0 = n_sweep;
        do_start(4'b0101, 1'b0, 2, 1'b1, 1'b1);
        for (int k = 0; k < 60 && run_en < 3; k++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        src_mask = 4'b0010;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("no_restart_while_busy", 32'({acc_clear, busy, src_sel}), 32'({1'b0, 1'b1, 2'd0}));
        wait_q_empty(200);
        wait_sweep(sweeps0, 40);
        check("busy_start_final_count", 32'(win_count), 32'(2));
        check("busy_start_sweeps", 32'(n_sweep - sweeps0), 32'(1));

        // Reset mid-LATCH, then a clean restart.
        do_start(4'b0001, 1'b0, 1, 1'b1, 1'b1);
        for (int k = 0; k < 80 && acc_hold !== 1'b1; k++) begin
            @(negedge clk); #1;
        end
        check("reached_latch", 32'(acc_hold), 32'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", outs(), 32'(0));
        @(negedge clk);
        reset_n = 1'b1;
        sb.delete();
        sweeps0 = n_sweep;
        do_start(4'b0100, 1'b0, 1, 1'b1, 1'b1);
        wait_q_empty(120);
        wait_sweep(sweeps0, 40);
        check("restart_final_count", 32'(win_count), 32'(1));
        check("restart_sweeps", 32'(n_sweep - sweeps0), 32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
